// File: rtl/bk_arb_pkg.sv
// Shared types and defaults for the two-requester backend register-bus arbiter.
// Contents: FSM state enum, default data/strobe widths, timeout read data,
// and the 2-way round-robin pick used by the grant logic.
package bk_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_START,
        RD_WAIT,
        RESP
    } arb_state_t;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_STRB_WIDTH = DEF_DATA_WIDTH / 8;
    localparam logic [DEF_DATA_WIDTH-1:0] DEF_TIMEOUT_DATA = 32'hFFFF_FFFF;

    // The pointed-to requester wins if it has anything pending, else the other one.
    function automatic logic pick_grant(input logic rr, input logic [1:0] has_req);
        return has_req[rr] ? rr : ~rr;
    endfunction

endpackage

// File: rtl/bk_arb_rr.sv
// 2-way round-robin grant select for the backend arbiter (combinational).
// Ports:
//   rr          - current round-robin pointer (requester favoured this round)
//   wreq/rreq   - per-requester write/read request levels
//   any_req_c   - at least one requester has a pending request
//   grant_c     - index of the requester that would be granted now
//   grant_wr_c  - granted requester is served as a write (write beats read)
//   next_rr_c   - pointer value after this grant (the non-granted requester)
module bk_arb_rr
    import bk_arb_pkg::*;
(
    input  logic       rr,
    input  logic [1:0] wreq,
    input  logic [1:0] rreq,
    output logic       any_req_c,
    output logic       grant_c,
    output logic       grant_wr_c,
    output logic       next_rr_c
);

    logic [1:0] has_req_c;

    assign has_req_c  = wreq | rreq;
    assign any_req_c  = |has_req_c;
    assign grant_c    = pick_grant(rr, has_req_c);
    assign grant_wr_c = wreq[grant_c];
    assign next_rr_c  = ~grant_c;

endmodule

// File: rtl/bk_arbiter.sv
// Shares one start/done backend register bus between two requesters with
// round-robin fairness; every read is bounded by a timeout.
// Ports:
//   axi_aclk, axi_areset          - clock, synchronous active-high reset
//   cc_aa_enable                  - allows new grants (sampled in IDLE only)
//   sN_wreq/waddr/wdata/wstrb     - requester N write request + payload
//   sN_rreq/raddr                 - requester N read request + address
//   sN_wdone, sN_rdone, sN_rdata  - requester N completions and read data
//   bk_wstart/waddr/wdata/wstrb   - one-cycle write strobe + payload to target
//   bk_rstart/raddr               - one-cycle read start + address to target
//   bk_rdata/bk_rdone             - target read response
//   timeout_err, err_src          - read timeout pulse, source of last timeout
module bk_arbiter
    import bk_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = DATA_WIDTH'(DEF_TIMEOUT_DATA),
    localparam int unsigned STRB_WIDTH    = DATA_WIDTH / 8
) (
    input  logic                  axi_aclk,
    input  logic                  axi_areset,
    input  logic                  cc_aa_enable,
    input  logic                  s0_wreq,
    input  logic [ADDR_WIDTH-1:0] s0_waddr,
    input  logic [DATA_WIDTH-1:0] s0_wdata,
    input  logic [STRB_WIDTH-1:0] s0_wstrb,
    input  logic                  s0_rreq,
    input  logic [ADDR_WIDTH-1:0] s0_raddr,
    output logic                  s0_wdone,
    output logic                  s0_rdone,
    output logic [DATA_WIDTH-1:0] s0_rdata,
    input  logic                  s1_wreq,
    input  logic [ADDR_WIDTH-1:0] s1_waddr,
    input  logic [DATA_WIDTH-1:0] s1_wdata,
    input  logic [STRB_WIDTH-1:0] s1_wstrb,
    input  logic                  s1_rreq,
    input  logic [ADDR_WIDTH-1:0] s1_raddr,
    output logic                  s1_wdone,
    output logic                  s1_rdone,
    output logic [DATA_WIDTH-1:0] s1_rdata,
    output logic                  bk_wstart,
    output logic [ADDR_WIDTH-1:0] bk_waddr,
    output logic [DATA_WIDTH-1:0] bk_wdata,
    output logic [STRB_WIDTH-1:0] bk_wstrb,
    output logic                  bk_rstart,
    output logic [ADDR_WIDTH-1:0] bk_raddr,
    input  logic [DATA_WIDTH-1:0] bk_rdata,
    input  logic                  bk_rdone,
    output logic                  timeout_err,
    output logic                  err_src
);

    localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t           state;
    logic                 rr;
    logic                 gnt;
    logic [CNT_WIDTH-1:0] cnt;

    logic                  any_req_c;
    logic                  grant_c;
    logic                  grant_wr_c;
    logic                  next_rr_c;
    logic [ADDR_WIDTH-1:0] sel_waddr_c;
    logic [DATA_WIDTH-1:0] sel_wdata_c;
    logic [STRB_WIDTH-1:0] sel_wstrb_c;
    logic [ADDR_WIDTH-1:0] sel_raddr_c;
    logic                  rd_fin_c;
    logic [DATA_WIDTH-1:0] rd_val_c;

    bk_arb_rr u_rr (
        .rr         (rr),
        .wreq       ({s1_wreq, s0_wreq}),
        .rreq       ({s1_rreq, s0_rreq}),
        .any_req_c  (any_req_c),
        .grant_c    (grant_c),
        .grant_wr_c (grant_wr_c),
        .next_rr_c  (next_rr_c)
    );

    // Payload of the requester about to be granted.
    assign sel_waddr_c = grant_c ? s1_waddr : s0_waddr;
    assign sel_wdata_c = grant_c ? s1_wdata : s0_wdata;
    assign sel_wstrb_c = grant_c ? s1_wstrb : s0_wstrb;
    assign sel_raddr_c = grant_c ? s1_raddr : s0_raddr;

    // A target response in the same cycle as the limit still delivers real data.
    assign rd_fin_c = bk_rdone || (cnt == CNT_WIDTH'(TIMEOUT_CYCLES));
    assign rd_val_c = bk_rdone ? bk_rdata : TIMEOUT_DATA;

    // Arbitration FSM with registered bus and completion outputs.
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state       <= IDLE;
            rr          <= 1'b0;
            gnt         <= 1'b0;
            cnt         <= '0;
            bk_wstart   <= 1'b0;
            bk_waddr    <= '0;
            bk_wdata    <= '0;
            bk_wstrb    <= '0;
            bk_rstart   <= 1'b0;
            bk_raddr    <= '0;
            s0_wdone    <= 1'b0;
            s1_wdone    <= 1'b0;
            s0_rdone    <= 1'b0;
            s1_rdone    <= 1'b0;
            s0_rdata    <= '0;
            s1_rdata    <= '0;
            timeout_err <= 1'b0;
            err_src     <= 1'b0;
        end else begin
            bk_wstart   <= 1'b0;
            bk_rstart   <= 1'b0;
            s0_wdone    <= 1'b0;
            s1_wdone    <= 1'b0;
            s0_rdone    <= 1'b0;
            s1_rdone    <= 1'b0;
            timeout_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (cc_aa_enable && any_req_c) begin
                        gnt <= grant_c;
                        rr  <= next_rr_c;
                        if (grant_wr_c) begin
                            bk_wstart <= 1'b1;
                            bk_waddr  <= sel_waddr_c;
                            bk_wdata  <= sel_wdata_c;
                            bk_wstrb  <= sel_wstrb_c;
                            state     <= WR;
                        end else begin
                            bk_rstart <= 1'b1;
                            bk_raddr  <= sel_raddr_c;
                            state     <= RD_START;
                        end
                    end
                end
                WR: begin
                    s0_wdone <= ~gnt;
                    s1_wdone <= gnt;
                    state    <= RESP;
                end
                RD_START: begin
                    cnt   <= '0;
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (rd_fin_c) begin
                        s0_rdone <= ~gnt;
                        s1_rdone <= gnt;
                        if (gnt) begin
                            s1_rdata <= rd_val_c;
                        end else begin
                            s0_rdata <= rd_val_c;
                        end
                        if (!bk_rdone) begin
                            timeout_err <= 1'b1;
                            err_src     <= gnt;
                        end
                        state <= RESP;
                    end else begin
                        // Only reached below the limit, so the counter never wraps.
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bk_arbiter.sv
// Self-checking bench for bk_arbiter: directed vector table, hand-written
// multi-cycle sequences and a randomized phase against a transaction-level model.
`timescale 1ns/1ps
module tb_bk_arbiter;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned TO = 4;
    localparam int NR = 1500;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [1:0]    wreq;
    logic [1:0]    rreq;
    logic [AW-1:0] waddr [2];
    logic [DW-1:0] wdata [2];
    logic [SW-1:0] wstrb [2];
    logic [AW-1:0] raddr [2];
    logic          s0_wdone, s1_wdone, s0_rdone, s1_rdone;
    logic [DW-1:0] s0_rdata, s1_rdata;
    logic          bk_wstart, bk_rstart, bk_rdone, timeout_err, err_src;
    logic [AW-1:0] bk_waddr, bk_raddr;
    logic [DW-1:0] bk_wdata, bk_rdata;
    logic [SW-1:0] bk_wstrb;

    always #5 clk = ~clk;

    bk_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO),
        .TIMEOUT_DATA   (32'hFFFF_FFFF)
    ) dut (
        .axi_aclk     (clk),
        .axi_areset   (rst),
        .cc_aa_enable (en),
        .s0_wreq      (wreq[0]),
        .s0_waddr     (waddr[0]),
        .s0_wdata     (wdata[0]),
        .s0_wstrb     (wstrb[0]),
        .s0_rreq      (rreq[0]),
        .s0_raddr     (raddr[0]),
        .s0_wdone     (s0_wdone),
        .s0_rdone     (s0_rdone),
        .s0_rdata     (s0_rdata),
        .s1_wreq      (wreq[1]),
        .s1_waddr     (waddr[1]),
        .s1_wdata     (wdata[1]),
        .s1_wstrb     (wstrb[1]),
        .s1_rreq      (rreq[1]),
        .s1_raddr     (raddr[1]),
        .s1_wdone     (s1_wdone),
        .s1_rdone     (s1_rdone),
        .s1_rdata     (s1_rdata),
        .bk_wstart    (bk_wstart),
        .bk_waddr     (bk_waddr),
        .bk_wdata     (bk_wdata),
        .bk_wstrb     (bk_wstrb),
        .bk_rstart    (bk_rstart),
        .bk_raddr     (bk_raddr),
        .bk_rdata     (bk_rdata),
        .bk_rdone     (bk_rdone),
        .timeout_err  (timeout_err),
        .err_src      (err_src)
    );

    logic [1:0]    wdone_v, rdone_v;
    logic [DW-1:0] rdata_v [2];
    logic          any_out;
    assign wdone_v    = {s1_wdone, s0_wdone};
    assign rdone_v    = {s1_rdone, s0_rdone};
    assign rdata_v[0] = s0_rdata;
    assign rdata_v[1] = s1_rdata;
    assign any_out = |{bk_wstart, bk_waddr, bk_wdata, bk_wstrb, bk_rstart, bk_raddr,
                       s0_wdone, s1_wdone, s0_rdone, s1_rdone, s0_rdata, s1_rdata,
                       timeout_err, err_src};

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Directed transaction vectors: delay is the target response cycle counted from bk_rstart.
    typedef struct {
        bit            is_rd;
        bit            src;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        int            delay;
        int            exp_start;
        int            exp_done;
        logic [DW-1:0] exp_rdata;
        bit            exp_to;
    } vec_t;

    // Expected per-cycle events for the randomized phase.
    typedef struct {
        bit            wstart;
        bit            rstart;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
        logic [1:0]    wdone;
        logic [1:0]    rdone;
        logic [DW-1:0] rdata;
        bit            to;
        bit            err_src;
    } ev_t;

    vec_t          vecs [8];
    vec_t          v;
    ev_t           ev [NR+40];
    int            k_start, k_done, n_start, n_other, n, last_k, n_ws, prev_src, cur_src;
    int            done_at [2];
    logic [DW-1:0] got_data;
    logic          got_to, got_src;
    bit            m_rr, m_err, g;
    int            m_free, resp_at, d, dn;
    logic [DW-1:0] resp_data;
    logic [1:0]    seen, has;

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b1; wreq = '0; rreq = '0; bk_rdone = 1'b0; bk_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            waddr[i] = '0; wdata[i] = '0; wstrb[i] = '0; raddr[i] = '0;
        end

        vecs[0] = '{1'b0, 1'b0, 12'h010, 32'hA5A5_0001, 4'hF, 0,  1, 2, 32'h0,         1'b0};
        vecs[1] = '{1'b1, 1'b0, 12'h020, 32'h1234_5678, 4'h0, 2,  1, 4, 32'h1234_5678, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 12'h0C4, 32'h0000_00DD, 4'h0, 99, 1, 7, 32'hFFFF_FFFF, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 12'h3FC, 32'hDEAD_BEEF, 4'h5, 0,  1, 2, 32'h0,         1'b0};
        vecs[4] = '{1'b1, 1'b1, 12'h100, 32'hCAFE_F00D, 4'h0, 1,  1, 3, 32'hCAFE_F00D, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 12'h044, 32'h0BAD_F00D, 4'h0, 5,  1, 7, 32'h0BAD_F00D, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 12'h048, 32'h1111_2222, 4'h0, 6,  1, 7, 32'hFFFF_FFFF, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 12'h04C, 32'h3333_4444, 4'h0, 0,  1, 7, 32'hFFFF_FFFF, 1'b1};

        repeat (2) @(negedge clk);
        chk("reset_outputs_nonzero", 64'(any_out), 64'd0);
        rst = 1'b0;

        // ---------------- directed vector table ----------------
        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            @(negedge clk);
            if (v.is_rd) begin
                rreq[v.src] = 1'b1; raddr[v.src] = v.addr;
            end else begin
                wreq[v.src] = 1'b1; waddr[v.src] = v.addr;
                wdata[v.src] = v.data; wstrb[v.src] = v.strb;
            end
            k_start = -1; k_done = -1; n_start = 0; n_other = 0;
            got_data = '0; got_to = 1'b0; got_src = 1'b0;
            for (int k = 1; k <= 20 && k_done < 0; k++) begin
                @(negedge clk);
                if (bk_wstart || bk_rstart) n_start++;
                if ((v.is_rd ? bk_rstart : bk_wstart) && k_start < 0) begin
                    k_start = k;
                    if (v.is_rd) begin
                        chk($sformatf("vec%0d_bk_raddr", i), 64'(bk_raddr), 64'(v.addr));
                    end else begin
                        chk($sformatf("vec%0d_bk_waddr", i), 64'(bk_waddr), 64'(v.addr));
                        chk($sformatf("vec%0d_bk_wdata", i), 64'(bk_wdata), 64'(v.data));
                        chk($sformatf("vec%0d_bk_wstrb", i), 64'(bk_wstrb), 64'(v.strb));
                    end
                end
                if (wdone_v[!v.src] || rdone_v[!v.src]) n_other++;
                if (v.is_rd ? rdone_v[v.src] : wdone_v[v.src]) begin
                    k_done = k; got_data = rdata_v[v.src]; got_to = timeout_err; got_src = err_src;
                end
                if (v.is_rd && k_start > 0 && k == k_start + v.delay) begin
                    bk_rdone = 1'b1; bk_rdata = v.data;
                end else begin
                    bk_rdone = 1'b0; bk_rdata = $urandom;
                end
            end
            @(negedge clk);
            wreq = '0; rreq = '0; bk_rdone = 1'b0;
            chk($sformatf("vec%0d_start_latency", i), 64'(k_start), 64'(v.exp_start));
            chk($sformatf("vec%0d_done_latency", i), 64'(k_done), 64'(v.exp_done));
            chk($sformatf("vec%0d_start_count", i), 64'(n_start), 64'd1);
            chk($sformatf("vec%0d_other_done", i), 64'(n_other), 64'd0);
            chk($sformatf("vec%0d_timeout_err", i), 64'(got_to), 64'(v.exp_to));
            if (v.is_rd) chk($sformatf("vec%0d_rdata", i), 64'(got_data), 64'(v.exp_rdata));
            if (v.exp_to) chk($sformatf("vec%0d_err_src", i), 64'(got_src), 64'(v.src));
        end

        // ---------------- timeout then late target response ----------------
        @(negedge clk);
        rreq[1] = 1'b1; raddr[1] = 12'h0F0;
        k_done = -1;
        for (int k = 1; k <= 12 && k_done < 0; k++) begin
            @(negedge clk);
            if (s1_rdone) begin
                k_done = k; got_data = s1_rdata; got_to = timeout_err; got_src = err_src;
            end
        end
        chk("late_timeout_latency", 64'(k_done), 64'(TO + 3));
        chk("late_timeout_rdata", 64'(got_data), 64'hFFFF_FFFF);
        chk("late_timeout_err", 64'(got_to), 64'd1);
        chk("late_timeout_src", 64'(got_src), 64'd1);
        @(negedge clk);
        rreq[1] = 1'b0; bk_rdone = 1'b1; bk_rdata = 32'h5555_AAAA;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            bk_rdone = 1'b0;
            n += int'(|{wdone_v, rdone_v, bk_wstart, bk_rstart, timeout_err});
        end
        chk("late_rdone_ignored", 64'(n), 64'd0);

        // ---------------- simultaneous continuous writes ----------------
        waddr[0] = 12'h111; wdata[0] = 32'h0000_0111; wstrb[0] = 4'hF;
        waddr[1] = 12'h222; wdata[1] = 32'h0000_0222; wstrb[1] = 4'hF;
        done_at[0] = -10; done_at[1] = -10;
        n_ws = 0; prev_src = -1; last_k = -1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (bk_wstart) begin
                cur_src = (bk_waddr == 12'h222) ? 1 : 0;
                if (n_ws > 0) begin
                    chk($sformatf("alt_grant_%0d", n_ws), 64'(cur_src != prev_src), 64'd1);
                    chk($sformatf("alt_spacing_%0d", n_ws), 64'(c - last_k), 64'd3);
                end
                prev_src = cur_src; last_k = c; n_ws++;
            end
            for (int i = 0; i < 2; i++) begin
                if (wdone_v[i]) done_at[i] = c;
                wreq[i] = (done_at[i] == c - 1) ? 1'b0 : 1'b1;
            end
        end
        wreq = '0;
        chk("alt_write_count", 64'(n_ws), 64'd8);
        repeat (4) @(negedge clk);

        // ---------------- enable held low ----------------
        en = 1'b0; wreq[0] = 1'b1; waddr[0] = 12'h055; wdata[0] = 32'h0000_0055; wstrb[0] = 4'h3;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            n += int'(bk_wstart);
        end
        chk("enable_low_no_start", 64'(n), 64'd0);
        en = 1'b1;
        @(negedge clk);
        chk("enable_rise_wstart", 64'(bk_wstart), 64'd1);
        chk("enable_rise_waddr", 64'(bk_waddr), 64'h055);
        @(negedge clk);
        chk("enable_rise_wdone", 64'(s0_wdone), 64'd1);
        @(negedge clk);
        wreq = '0;
        repeat (2) @(negedge clk);

        // ---------------- reset during RD_WAIT ----------------
        rreq[0] = 1'b1; raddr[0] = 12'h0AA;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_outputs_nonzero", 64'(any_out), 64'd0);
        chk("midreset_err_src", 64'(err_src), 64'd0);
        rst = 1'b0; rreq = '0;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            n += int'(|{wdone_v, rdone_v, bk_wstart, bk_rstart});
        end
        chk("midreset_no_done", 64'(n), 64'd0);
        wreq = 2'b11;
        waddr[0] = 12'h101; waddr[1] = 12'h202;
        @(negedge clk);
        chk("post_reset_s0_wins", 64'(bk_wstart), 64'd1);
        chk("post_reset_s0_addr", 64'(bk_waddr), 64'h101);
        @(negedge clk);
        chk("post_reset_s0_wdone", 64'(s0_wdone), 64'd1);
        @(negedge clk);
        wreq = '0;
        repeat (4) @(negedge clk);

        // ---------------- randomized phase against transaction model ----------------
        foreach (ev[i]) ev[i] = '{default: 0};
        do_reset();
        m_rr = 1'b0; m_err = 1'b0; m_free = 0; resp_at = -1; seen = '0; resp_data = '0;
        for (int t = 0; t < NR + 30; t++) begin
            @(negedge clk);
            if (ev[t].to) m_err = ev[t].err_src;
            chk($sformatf("rnd_wstart@%0d", t), 64'(bk_wstart), 64'(ev[t].wstart));
            chk($sformatf("rnd_rstart@%0d", t), 64'(bk_rstart), 64'(ev[t].rstart));
            chk($sformatf("rnd_wdone@%0d", t), 64'(wdone_v), 64'(ev[t].wdone));
            chk($sformatf("rnd_rdone@%0d", t), 64'(rdone_v), 64'(ev[t].rdone));
            chk($sformatf("rnd_timeout@%0d", t), 64'(timeout_err), 64'(ev[t].to));
            chk($sformatf("rnd_err_src@%0d", t), 64'(err_src), 64'(m_err));
            if (ev[t].wstart) begin
                chk($sformatf("rnd_waddr@%0d", t), 64'(bk_waddr), 64'(ev[t].addr));
                chk($sformatf("rnd_wdata@%0d", t), 64'(bk_wdata), 64'(ev[t].wdata));
                chk($sformatf("rnd_wstrb@%0d", t), 64'(bk_wstrb), 64'(ev[t].wstrb));
            end
            if (ev[t].rstart) chk($sformatf("rnd_raddr@%0d", t), 64'(bk_raddr), 64'(ev[t].addr));
            for (int i = 0; i < 2; i++) begin
                if (ev[t].rdone[i]) chk($sformatf("rnd_rdata%0d@%0d", i, t), 64'(rdata_v[i]), 64'(ev[t].rdata));
            end

            // Requesters: drop the cycle after done, otherwise occasionally issue new work.
            for (int i = 0; i < 2; i++) begin
                if (seen[i]) begin
                    wreq[i] = 1'b0; rreq[i] = 1'b0; seen[i] = 1'b0;
                end else if (wreq[i] || rreq[i]) begin
                    if (wdone_v[i] || rdone_v[i]) seen[i] = 1'b1;
                end else if (t < NR && $urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 1) == 1) begin
                        wreq[i] = 1'b1; waddr[i] = AW'($urandom);
                        wdata[i] = $urandom; wstrb[i] = SW'($urandom);
                    end else begin
                        rreq[i] = 1'b1; raddr[i] = AW'($urandom);
                    end
                end
            end
            en = ($urandom_range(0, 7) != 0);
            if (t == resp_at) begin
                bk_rdone = 1'b1; bk_rdata = resp_data;
            end else begin
                bk_rdone = 1'b0; bk_rdata = $urandom;
            end

            // Model: one transaction at a time, round-robin pick, fixed latencies.
            has = wreq | rreq;
            if (t >= m_free && en && has != 2'b00) begin
                g = has[m_rr] ? m_rr : !m_rr;
                m_rr = !g;
                if (wreq[g]) begin
                    ev[t+1].wstart = 1'b1; ev[t+1].addr = waddr[g];
                    ev[t+1].wdata = wdata[g]; ev[t+1].wstrb = wstrb[g];
                    ev[t+2].wdone[g] = 1'b1;
                    m_free = t + 3;
                end else begin
                    ev[t+1].rstart = 1'b1; ev[t+1].addr = raddr[g];
                    d = int'($urandom_range(0, 7));
                    resp_at = t + 1 + d;
                    resp_data = $urandom;
                    if (d >= 1 && d <= int'(TO) + 1) begin
                        dn = t + 2 + d;
                        ev[dn].rdata = resp_data;
                    end else begin
                        dn = t + int'(TO) + 3;
                        ev[dn].rdata = 32'hFFFF_FFFF;
                        ev[dn].to = 1'b1;
                        ev[dn].err_src = g;
                    end
                    ev[dn].rdone[g] = 1'b1;
                    m_free = dn + 1;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
